// File: rtl/ifm_window_addr_gen.sv
// IFM window read-address generator for the systolic conv datapath.
// Walks every KxK window of a channel-major IFM, column-major over windows.
module ifm_window_addr_gen #(
  parameter int KERNEL_SIZE = 3,
  parameter int IFM_SIZE    = 34,
  parameter int IFM_CHANNEL = 3,
  parameter int STRIDE      = 1,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] ifm_addr,
  output logic                  addr_valid,
  output logic                  last_in_window,
  output logic                  last_window,
  output logic                  busy,
  output logic                  done
);

  localparam int OFM_SIZE = (IFM_SIZE - KERNEL_SIZE) / STRIDE + 1;

  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int CW = (IFM_CHANNEL > 1) ? $clog2(IFM_CHANNEL) : 1;
  localparam int OW = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

  localparam logic [KW-1:0] K_MAX = KW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] C_MAX = CW'(IFM_CHANNEL - 1);
  localparam logic [OW-1:0] O_MAX = OW'(OFM_SIZE - 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ROW_STEP   = addr_t'(IFM_SIZE);
  localparam addr_t PLANE_STEP = addr_t'(IFM_SIZE * IFM_SIZE);
  localparam addr_t WIN_STEP   = addr_t'(STRIDE * IFM_SIZE);
  localparam addr_t COL_STEP   = addr_t'(STRIDE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0] c_q, c_d;
  logic [OW-1:0] oy_q, oy_d, ox_q, ox_d;

  // addr: current pixel; row: start of current kernel row;
  // plane: window origin in current channel; win: window origin
  // in channel 0; col: top window origin of current output column.
  addr_t addr_q, addr_d;
  addr_t row_q, row_d;
  addr_t plane_q, plane_d;
  addr_t win_q, win_d;
  addr_t col_q, col_d;

  logic hs;
  logic kx_end, ky_end, c_end, oy_end, ox_end;

  assign hs     = (state_q == S_RUN) & addr_ready;
  assign kx_end = (kx_q == K_MAX);
  assign ky_end = (ky_q == K_MAX);
  assign c_end  = (c_q == C_MAX);
  assign oy_end = (oy_q == O_MAX);
  assign ox_end = (ox_q == O_MAX);

  // Next-state and running-offset update, one step per handshake.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    c_d     = c_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    addr_d  = addr_q;
    row_d   = row_q;
    plane_d = plane_q;
    win_d   = win_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          kx_d    = '0;
          ky_d    = '0;
          c_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          addr_d  = base_addr;
          row_d   = base_addr;
          plane_d = base_addr;
          win_d   = base_addr;
          col_d   = base_addr;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (!kx_end) begin
            kx_d   = kx_q + KW'(1);
            addr_d = addr_q + addr_t'(1);
          end else begin
            kx_d = '0;
            if (!ky_end) begin
              ky_d   = ky_q + KW'(1);
              row_d  = row_q + ROW_STEP;
              addr_d = row_q + ROW_STEP;
            end else begin
              ky_d = '0;
              if (!c_end) begin
                c_d     = c_q + CW'(1);
                plane_d = plane_q + PLANE_STEP;
                row_d   = plane_q + PLANE_STEP;
                addr_d  = plane_q + PLANE_STEP;
              end else begin
                c_d = '0;
                if (!oy_end) begin
                  oy_d    = oy_q + OW'(1);
                  win_d   = win_q + WIN_STEP;
                  plane_d = win_q + WIN_STEP;
                  row_d   = win_q + WIN_STEP;
                  addr_d  = win_q + WIN_STEP;
                end else begin
                  oy_d = '0;
                  if (!ox_end) begin
                    ox_d    = ox_q + OW'(1);
                    col_d   = col_q + COL_STEP;
                    win_d   = col_q + COL_STEP;
                    plane_d = col_q + COL_STEP;
                    row_d   = col_q + COL_STEP;
                    addr_d  = col_q + COL_STEP;
                  end else begin
                    ox_d    = '0;
                    state_d = S_DONE;
                  end
                end
              end
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and offset registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      c_q     <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      plane_q <= '0;
      win_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      c_q     <= c_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      win_q   <= win_d;
      col_q   <= col_d;
    end
  end

  assign ifm_addr       = addr_q;
  assign addr_valid     = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign last_in_window = addr_valid & kx_end & ky_end & c_end;
  assign last_window    = addr_valid & oy_end & ox_end;

endmodule

// File: doc/ifm_window_addr_gen.md
Name: ifm_window_addr_gen

Overview:
- Parametrised IFM read-address generator for the systolic convolution datapath.
- Sits between the layer sequencer and the IFM buffer read port.
- On `start`, walks every KxK convolution window of a C-channel, square, channel-major IFM.
- Supports configurable stride and base address, a valid/ready backpressure handshake, per-window and per-frame last flags, and a done pulse.
- Windows are traversed vertically: all output rows of one output column before moving to the next column.

Parameters:
- KERNEL_SIZE, 3, kernel height/width (>=1).
- IFM_SIZE, 34, IFM height/width in pixels (>= KERNEL_SIZE).
- IFM_CHANNEL, 3, number of input channels (>=1).
- STRIDE, 1, window step in pixels, both directions (>=1).
- ADDR_WIDTH, 16, address width; must hold base_addr + IFM_CHANNEL*IFM_SIZE*IFM_SIZE - 1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a frame; accepted only in IDLE.
- base_addr, input, ADDR_WIDTH, address of pixel (c=0,row=0,col=0); sampled on the accepted start.
- addr_ready, input, 1, consumer accepts the current address when high with addr_valid.
- ifm_addr, output, ADDR_WIDTH, current read address.
- addr_valid, output, 1, ifm_addr is valid.
- last_in_window, output, 1, current address is the final (c, ky, kx) of its window.
- last_window, output, 1, current address belongs to the final window of the frame.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse after the final address handshake.

Behaviour:
- Derived quantities:
  - OFM_SIZE = (IFM_SIZE-KERNEL_SIZE)/STRIDE + 1 (integer division).
  - PLANE = IFM_SIZE*IFM_SIZE.
- Address formula: ifm_addr = base + c*PLANE + (oy*STRIDE+ky)*IFM_SIZE + ox*STRIDE + kx.
  - Loop order, innermost first: kx, ky, c, oy, ox.
  - Computed with running adders and registered row/plane/window-start offsets; no runtime multipliers.
  - Arithmetic is modulo 2^ADDR_WIDTH.
- Reset: state=IDLE; ifm_addr=0, addr_valid=0, last_in_window=0, last_window=0, busy=0, done=0; all counters 0.
- States:
  - IDLE: busy=0, addr_valid=0. On start, latch base_addr, load first address = base_addr, go to RUN. busy and addr_valid go high the cycle after start (latency 1).
  - RUN: addr_valid=1.
    - Handshake = addr_valid & addr_ready. Without a handshake, ifm_addr and all flags hold.
    - On a handshake, advance one step: kx++.
      - kx wrap -> ky++.
      - ky wrap -> c++.
      - c wrap -> oy++ (window start += STRIDE*IFM_SIZE).
      - oy wrap -> ox++, oy=0 (window start = base + ox*STRIDE).
    - One address per cycle when addr_ready stays high; no bubbles, including at line, channel, window and column boundaries.
    - Handshake on the final address (kx,ky,c,oy,ox all at max) -> DONE.
  - DONE: addr_valid=0, done=1 for exactly one cycle, busy=0 in this same cycle; then IDLE.
- Flags:
  - last_in_window = (kx==K-1 && ky==K-1 && c==C-1), combinational from registered counters, qualified by addr_valid.
  - last_window = (oy==OFM_SIZE-1 && ox==OFM_SIZE-1), qualified by addr_valid.
- start while busy, or in the DONE cycle, is ignored; base_addr changes during RUN have no effect.
- Degenerate K=1: every address is last_in_window once c==C-1; the window advances every C handshakes.
- Degenerate OFM_SIZE=1: a single window of K*K*C addresses.
- Reset asserted mid-frame: immediate return to reset values; next start begins a fresh frame.
- Total handshakes per frame = OFM_SIZE^2 * K^2 * C, exactly.

Test Plan:
- K=3, IFM=5, C=2, S=1, base=0, addr_ready=1:
  - First 18 addresses: 0,1,2,5,6,7,10,11,12,25,26,27,30,31,32,35,36,37, last_in_window high on 37.
  - Second window starts at 5; fourth window (ox=1,oy=0) starts at 1.
  - Final address 49 with last_window=1, last_in_window=1.
  - done pulses 1 cycle after the 162nd handshake; busy low in the same cycle.
- Same config, base=100:
  - First address 100, final address 149.
  - Exactly 162 handshakes.
- K=3, IFM=5, C=1, S=2:
  - OFM=2; window starts 0,10,2,12 in that order.
  - 36 total handshakes; final address 24.
- Backpressure:
  - Toggle addr_ready pseudo-randomly.
  - ifm_addr and flags hold while addr_ready=0.
  - The handshaked address sequence is identical to the addr_ready=1 run.
  - done only after the final handshake.
- start pulsed during RUN and in the DONE cycle -> ignored, sequence unaffected; start in IDLE after done -> new frame from the new base_addr.
- Assert rst_n low at handshake 50 -> outputs 0 immediately, state IDLE; next start replays the sequence from address base.
